conv_pe_sequencer: RTL and testbench
====================================

Name: conv_pe_sequencer

Overview:
- Controller that sequences a depth-D processing-element MAC chain for a 1-D, stride-1 convolution.
- For each output pixel it issues K taps. Each tap carries an input-buffer address, a weight address, an accumulate enable and a psum-clear on the first tap.
- It tracks the chain's fixed latency D and flags each finished output with valid and index.
- Sits between the layer-level control (start/done) and the PE chain plus its input/weight buffers.

Parameters:
K, 9, taps per output pixel (>=1)
D, 3, datapath latency in cycles from tap issue to result at chain output (>=1)
AW, 10, input/weight buffer address width
CW, 16, output-count / index width

Ports:
i_clk  input  1  clock
i_rst  input  1  synchronous reset, active-high
i_start  input  1  start request, sampled in IDLE only
i_num_out  input  CW  number of output pixels, latched on accepted start
i_base_addr  input  AW  input-buffer base address, latched on accepted start
i_stall  input  1  buffer not ready; suppresses issue this cycle
o_busy  output  1  high in RUN, DRAIN, DONE
o_done  output  1  one-cycle pulse at job completion
o_err  output  1  one-cycle pulse when i_start is seen while not IDLE
o_x_addr  output  AW  input-buffer read address
o_w_addr  output  AW  weight-buffer read address
o_acc_en  output  1  tap valid: PE chain accumulates this cycle
o_psum_clr  output  1  first tap of an output: chain psum restarts from zero
o_out_valid  output  1  chain output holds a finished pixel this cycle
o_out_idx  output  CW  index of that pixel

Behaviour:
- Reset (synchronous):
  - All outputs go to 0, state IDLE, all counters 0.
  - The D-stage valid/index delay line is cleared.
  - Applies mid-job too: the job is abandoned, and no o_done or o_out_valid appears afterwards.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - i_start=1 with i_num_out>0: latch num/base, clear tap counter t and pixel counter p, go to RUN.
  - i_start=1 with i_num_out=0: go to DONE directly, with no issue.
- RUN:
  - Each cycle with i_stall=0 issues one tap:
    - o_acc_en=1
    - o_x_addr = (base + p + t) mod 2^AW
    - o_w_addr = t
    - o_psum_clr = (t==0)
  - Then t increments. At t==K-1, t wraps to 0 and p increments.
  - With i_stall=1: o_acc_en=0, o_psum_clr=0, counters frozen, addresses hold their last values.
  - After the last tap (t==K-1, p==num-1): go to DRAIN.
- Delay line:
  - The marker "last tap of pixel p" enters a D-deep shift register each cycle (bubble when no last tap). It always shifts, including during stall.
  - o_out_valid/o_out_idx = stage D output, i.e. the last-tap issue cycle c yields o_out_valid in cycle c+D with o_out_idx=p.
- DRAIN: stays exactly D cycles (down-counter), o_acc_en=0, then goes to DONE.
- DONE: o_done=1 for one cycle, then IDLE. o_busy=1 throughout DONE.
- i_start while not IDLE: ignored, o_err=1 that cycle. A start in the DONE cycle is also ignored with o_err.
- Widths:
  - Address sum is computed in AW+CW bits and truncated to AW (wrap-around is legal).
  - p counts in CW bits, and num_out max is 2^CW-1.
- Throughput: one tap per unstalled cycle. No bubble between consecutive pixels.

Test Plan:
- K=3, D=2, base=10, num=2, start in cycle 0, no stall:
  - o_acc_en in cycles 1-6.
  - o_x_addr 10,11,12,11,12,13 and o_w_addr 0,1,2,0,1,2.
  - o_psum_clr in cycles 1 and 4.
  - o_out_valid in cycles 5 (idx 0) and 8 (idx 1).
  - DRAIN in cycles 7-8, o_done in cycle 9, o_busy in cycles 1-9.
- Same job with i_stall=1 in cycles 2-3:
  - Issue sequence is unchanged but shifted by 2 cycles.
  - o_out_valid in cycles 7 and 10.
  - o_done in cycle 11.
  - No o_acc_en during stall.
- num=0 start: o_done in cycle 1, no o_acc_en or o_out_valid, o_busy high in cycle 1 only.
- base=1022, AW=10, K=3, num=2: o_x_addr 1022,1023,0,1023,0,1 (wrap).
- i_start pulsed in cycle 3 of a running job: o_err=1 in cycle 3, job unaffected. i_start in cycle 9 (DONE) gives o_err=1, and IDLE is reached in cycle 10.
- i_rst asserted in cycle 4 of the first scenario:
  - All outputs 0 from cycle 5.
  - No o_out_valid/o_done thereafter.
  - A new start in cycle 6 runs cleanly from addr=base.

Source files
------------

// File: rtl/conv_pe_sequencer.sv
// Tap sequencer for a depth-D PE MAC chain doing a 1-D stride-1 convolution.
// Issues K taps per output pixel and marks finished pixels D cycles after their last tap.
module conv_pe_sequencer #(
    parameter int K  = 9,
    parameter int D  = 3,
    parameter int AW = 10,
    parameter int CW = 16
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic [CW-1:0] i_num_out,
    input  logic [AW-1:0] i_base_addr,
    input  logic          i_stall,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_err,
    output logic [AW-1:0] o_x_addr,
    output logic [AW-1:0] o_w_addr,
    output logic          o_acc_en,
    output logic          o_psum_clr,
    output logic          o_out_valid,
    output logic [CW-1:0] o_out_idx
);

    localparam int TW = (K > 1) ? $clog2(K) : 1;
    localparam int DW = (D > 1) ? $clog2(D) : 1;
    localparam int SW = AW + CW;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t        state, state_nx;
    logic [TW-1:0] t;
    logic [CW-1:0] p;
    logic [CW-1:0] num;
    logic [AW-1:0] base;
    logic [DW-1:0] dcnt;
    logic [AW-1:0] x_hold;
    logic [AW-1:0] w_hold;
    logic [D-1:0]  vline;
    logic [CW-1:0] iline [D];

    logic          issue;
    logic          pix_end;
    logic          last_tap;
    logic [SW-1:0] sum;

    always_comb begin
        issue    = (state == RUN) && !i_stall;
        pix_end  = (t == TW'(K - 1));
        last_tap = issue && pix_end && (p == num - CW'(1));
        sum      = SW'(base) + SW'(p) + SW'(t);

        state_nx = state;
        case (state)
            IDLE:  if (i_start) state_nx = (i_num_out == '0) ? DONE : RUN;
            RUN:   if (last_tap) state_nx = DRAIN;
            DRAIN: if (dcnt == '0) state_nx = DONE;
            DONE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase

        o_busy      = (state != IDLE);
        o_done      = (state == DONE);
        o_err       = i_start && (state != IDLE);
        o_acc_en    = issue;
        o_psum_clr  = issue && (t == '0);
        // Addresses show the tap being issued, otherwise the last issued tap.
        o_x_addr    = issue ? sum[AW-1:0] : x_hold;
        o_w_addr    = issue ? AW'(t) : w_hold;
        o_out_valid = vline[D-1];
        o_out_idx   = vline[D-1] ? iline[D-1] : '0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state  <= IDLE;
            t      <= '0;
            p      <= '0;
            num    <= '0;
            base   <= '0;
            dcnt   <= '0;
            x_hold <= '0;
            w_hold <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (i_start && (i_num_out != '0)) begin
                        num  <= i_num_out;
                        base <= i_base_addr;
                        t    <= '0;
                        p    <= '0;
                    end
                end
                RUN: begin
                    if (issue) begin
                        x_hold <= sum[AW-1:0];
                        w_hold <= AW'(t);
                        if (pix_end) begin
                            t <= '0;
                            p <= p + CW'(1);
                        end else begin
                            t <= t + TW'(1);
                        end
                    end
                    if (last_tap) dcnt <= DW'(D - 1);
                end
                DRAIN: begin
                    if (dcnt != '0) dcnt <= dcnt - DW'(1);
                end
                default: ;
            endcase
        end
    end

    // Completion markers shift every cycle, stalled or not, so results stay D behind issue.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            vline <= '0;
            for (int unsigned i = 0; i < D; i++) iline[i] <= '0;
        end else begin
            vline[0] <= issue && pix_end;
            iline[0] <= p;
            for (int unsigned i = 1; i < D; i++) begin
                vline[i] <= vline[i-1];
                iline[i] <= iline[i-1];
            end
        end
    end

endmodule

// File: tb/tb_conv_pe_sequencer.sv
// Randomized bench for conv_pe_sequencer against a queue-based job model.
module tb_conv_pe_sequencer;

    localparam int K  = 3;
    localparam int D  = 2;
    localparam int AW = 10;
    localparam int CW = 16;
    localparam int AMOD = 1 << AW;
    localparam int LIMIT = 3000;

    logic          i_clk;
    logic          i_rst;
    logic          i_start;
    logic [CW-1:0] i_num_out;
    logic [AW-1:0] i_base_addr;
    logic          i_stall;
    logic          o_busy;
    logic          o_done;
    logic          o_err;
    logic [AW-1:0] o_x_addr;
    logic [AW-1:0] o_w_addr;
    logic          o_acc_en;
    logic          o_psum_clr;
    logic          o_out_valid;
    logic [CW-1:0] o_out_idx;

    conv_pe_sequencer #(.K(K), .D(D), .AW(AW), .CW(CW)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_start    (i_start),
        .i_num_out  (i_num_out),
        .i_base_addr(i_base_addr),
        .i_stall    (i_stall),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_err      (o_err),
        .o_x_addr   (o_x_addr),
        .o_w_addr   (o_w_addr),
        .o_acc_en   (o_acc_en),
        .o_psum_clr (o_psum_clr),
        .o_out_valid(o_out_valid),
        .o_out_idx  (o_out_idx)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        int x;
        int w;
        bit clr;
        bit last;
        int idx;
    } tap_t;

    int n_cmp = 0;
    int n_bad = 0;
    int last_x = 0;
    int last_w = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_busy"},  32'(o_busy), 0);
        check({tag, "_done"},  32'(o_done), 0);
        check({tag, "_acc"},   32'(o_acc_en), 0);
        check({tag, "_clr"},   32'(o_psum_clr), 0);
        check({tag, "_valid"}, 32'(o_out_valid), 0);
        check({tag, "_idx"},   32'(o_out_idx), 0);
        check({tag, "_x"},     32'(o_x_addr), 0);
        check({tag, "_w"},     32'(o_w_addr), 0);
    endtask

    // Cycle 0 of a job is the start cycle; every later cycle is predicted from
    // the list of taps still owed and the cycles at which results must emerge.
    task automatic run_job(input int base, input int num, input int stall_pct,
                           input int err_pct, input logic [31:0] stall_mask,
                           input logic [31:0] err_mask);
        tap_t taps[$];
        int   outc[$];
        int   outi[$];
        int   done_c;
        bit   ss, st, exp_acc, exp_v;
        tap_t tp;
        for (int p = 0; p < num; p++)
            for (int t = 0; t < K; t++)
                taps.push_back('{(base + p + t) % AMOD, t, t == 0, t == K - 1, p});

        i_start = 1'b1;
        i_num_out = CW'(num);
        i_base_addr = AW'(base);
        i_stall = 1'($urandom_range(1));
        @(negedge i_clk);
        check("start_busy", 32'(o_busy), 0);
        check("start_err", 32'(o_err), 0);
        check("start_acc", 32'(o_acc_en), 0);
        @(posedge i_clk);
        #1;

        done_c = (num == 0) ? 1 : (1 << 30);
        for (int n = 1; n <= done_c + 1; n++) begin
            if (n > LIMIT) begin
                check("job_bound", 32'(n), 32'(LIMIT));
                break;
            end
            ss = (n < 32 && stall_mask[n]) || ($urandom_range(99) < 32'(stall_pct));
            st = (n <= done_c) &&
                 ((n < 32 && err_mask[n]) || ($urandom_range(99) < 32'(err_pct)));
            i_stall = ss;
            i_start = st;
            i_num_out = CW'($urandom);
            i_base_addr = AW'($urandom);
            exp_acc = (taps.size() > 0) && !ss;
            @(negedge i_clk);
            check("acc_en", 32'(o_acc_en), 32'(exp_acc));
            if (exp_acc) begin
                tp = taps.pop_front();
                check("psum_clr", 32'(o_psum_clr), 32'(tp.clr));
                last_x = tp.x;
                last_w = tp.w;
                if (tp.last) begin
                    outc.push_back(n + D);
                    outi.push_back(tp.idx);
                end
                if (taps.size() == 0) done_c = n + D + 1;
            end else begin
                check("psum_clr_idle", 32'(o_psum_clr), 0);
            end
            check("x_addr", 32'(o_x_addr), 32'(last_x));
            check("w_addr", 32'(o_w_addr), 32'(last_w));
            exp_v = (outc.size() > 0) && (outc[0] == n);
            check("out_valid", 32'(o_out_valid), 32'(exp_v));
            if (exp_v) begin
                check("out_idx", 32'(o_out_idx), 32'(outi[0]));
                void'(outc.pop_front());
                void'(outi.pop_front());
            end
            check("done", 32'(o_done), 32'(n == done_c));
            check("busy", 32'(o_busy), 32'(n <= done_c));
            check("err", 32'(o_err), 32'(st));
            @(posedge i_clk);
            #1;
        end
        i_start = 1'b0;
        i_stall = 1'b0;
    endtask

    initial begin
        i_rst = 1'b1;
        i_start = 1'b0;
        i_num_out = '0;
        i_base_addr = '0;
        i_stall = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        @(negedge i_clk);
        check_quiet("reset");
        check("reset_err", 32'(o_err), 0);
        @(posedge i_clk);
        #1;

        run_job(10, 2, 0, 0, 32'h0, 32'h0);
        run_job(10, 2, 0, 0, 32'h0000_000C, 32'h0);
        run_job(10, 0, 0, 0, 32'h0, 32'h0);
        run_job(1022, 2, 0, 0, 32'h0, 32'h0);
        run_job(10, 2, 0, 0, 32'h0, 32'h0000_0208);

        // Reset in cycle 4 of a running job abandons it.
        i_start = 1'b1;
        i_num_out = CW'(2);
        i_base_addr = AW'(10);
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        for (int n = 1; n <= 3; n++) begin
            @(negedge i_clk);
            check("pre_rst_acc", 32'(o_acc_en), 1);
            check("pre_rst_x", 32'(o_x_addr), 32'(10 + n - 1));
            @(posedge i_clk);
            #1;
        end
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        last_x = 0;
        last_w = 0;
        @(negedge i_clk);
        check_quiet("post_rst");
        @(posedge i_clk);
        #1;
        run_job(10, 2, 0, 0, 32'h0, 32'h0);

        for (int j = 0; j < 25; j++)
            run_job(int'($urandom_range(AMOD - 1)), int'($urandom_range(7)),
                    30, 10, 32'h0, 32'h0);
        run_job(AMOD - 5, 20, 20, 5, 32'h0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
